uart_rx: RTL and testbench

//  UART 8N1 receiver: receive end of the link driven by the team's UART transmitter.

---
 rtl/uart_rx.sv | 134 +++++++++++++
 tb/tb_uart_rx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : UART 8N1 receiver with 2-flop input synchroniser and mid-bit sampling.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int CLOCK_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_RX_bit,
  output logic [7:0] o_RX_byte,
  output logic       o_RX_done,
  output logic       o_frame_err,
  output logic       o_receive_state
);

  localparam int c_HALF_BIT = (CLOCK_PER_BIT - 1) / 2;
  localparam int c_CNT_W    = $clog2(CLOCK_PER_BIT);

  localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(c_HALF_BIT);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLOCK_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  state_t               r_state;
  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [2:0]           r_idx;
  logic [7:0]           r_shift;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= S_IDLE;
      r_rx_meta       <= 1'b1;
      r_rx_s          <= 1'b1;
      r_cnt           <= '0;
      r_idx           <= '0;
      r_shift         <= '0;
      o_RX_byte       <= '0;
      o_RX_done       <= 1'b0;
      o_frame_err     <= 1'b0;
      o_receive_state <= 1'b0;
    end else begin
      r_rx_meta   <= i_RX_bit;
      r_rx_s      <= r_rx_meta;
      o_RX_done   <= 1'b0;
      o_frame_err <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_idx <= '0;
          if (!r_rx_s) begin
            r_state         <= S_START;
            o_receive_state <= 1'b1;
          end
        end

        S_START: begin
          if (r_cnt == c_CNT_HALF) begin
            r_cnt <= '0;
            if (!r_rx_s) begin
              r_state <= S_DATA;
            end else begin
              // Start bit gone by mid-bit: treat as a glitch, silently.
              r_state         <= S_IDLE;
              o_receive_state <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end

        S_DATA: begin
          if (r_cnt == c_CNT_LAST) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= r_rx_s;
            if (r_idx == 3'd7) begin
              r_idx   <= '0;
              r_state <= S_STOP;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end

        S_STOP: begin
          if (r_cnt == c_CNT_LAST) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              o_RX_byte <= r_shift;
              o_RX_done <= 1'b1;
            end else begin
              o_frame_err <= 1'b1;
            end
            r_state         <= S_CLEAR;
            o_receive_state <= 1'b0;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end

        S_CLEAR: begin
          // Wait for the line to return high so a held break cannot start a frame.
          r_cnt <= '0;
          if (r_rx_s) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state         <= S_IDLE;
          r_cnt           <= '0;
          r_idx           <= '0;
          o_receive_state <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Self-checking bench for uart_rx using a serial TX model and byte queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_byte;
  logic       done;
  logic       ferr;
  logic       rstate;

  always #5 clk = ~clk;

  uart_rx #(.CLOCK_PER_BIT(CPB)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_RX_bit        (rx),
    .o_RX_byte       (rx_byte),
    .o_RX_done       (done),
    .o_frame_err     (ferr),
    .o_receive_state (rstate)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: every frame with a high stop bit yields its byte, every low stop bit one error.
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         exp_err  = 0;
  int         err_cnt  = 0;
  int         both_cnt = 0;
  int         dbl_cnt  = 0;
  logic       prev_done = 1'b0;
  logic [7:0] last_good = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      prev_done <= 1'b0;
    end else begin
      if (done) got_q.push_back(rx_byte);
      if (ferr) err_cnt <= err_cnt + 1;
      if (done && ferr) both_cnt <= both_cnt + 1;
      if ((done && prev_done) || ferr && $past(ferr)) dbl_cnt <= dbl_cnt + 1;
      prev_done <= done;
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int per);
    rx = 1'b0;
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (per) @(negedge clk);
    end
    rx = stop_ok;
    repeat (per) @(negedge clk);
    if (stop_ok) begin
      exp_q.push_back(b);
      last_good = b;
    end else begin
      exp_err++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (rx_byte !== 8'h00) begin fails++; $display("FAIL reset_byte got %h want 00", rx_byte); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (ferr !== 1'b0) begin fails++; $display("FAIL reset_ferr got %b want 0", ferr); end
    tests++; if (rstate !== 1'b0) begin fails++; $display("FAIL reset_state got %b want 0", rstate); end
  endtask

  task automatic test_single();
    send_frame(8'hA5, 1'b1, CPB);
    idle(2 * CPB);
    tests++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL single_count got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      tests++; if (got_q[0] !== exp_q[0]) begin fails++; $display("FAIL single_byte got %h want %h", got_q[0], exp_q[0]); end
      void'(got_q.pop_front()); void'(exp_q.pop_front());
    end
    got_q.delete(); exp_q.delete();
    tests++; if (rx_byte !== 8'hA5) begin fails++; $display("FAIL single_hold got %h want a5", rx_byte); end
    tests++; if (err_cnt !== exp_err) begin fails++; $display("FAIL single_ferr got %0d want %0d", err_cnt, exp_err); end
    tests++; if (dbl_cnt !== 0) begin fails++; $display("FAIL single_pulse_width got %0d long pulses want 0", dbl_cnt); end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h00, 1'b1, CPB);
    send_frame(8'hFF, 1'b1, CPB);
    idle(2 * CPB);
    tests++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      tests++; if (got_q[0] !== exp_q[0]) begin fails++; $display("FAIL b2b_byte got %h want %h", got_q[0], exp_q[0]); end
      void'(got_q.pop_front()); void'(exp_q.pop_front());
    end
    got_q.delete(); exp_q.delete();
    tests++; if (err_cnt !== exp_err) begin fails++; $display("FAIL b2b_ferr got %0d want %0d", err_cnt, exp_err); end
  endtask

  task automatic test_glitch();
    int  err0;
    int  wait_n;
    err0 = err_cnt;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (rstate !== 1'b1) begin fails++; $display("FAIL glitch_seen got %b want 1", rstate); end
    rx = 1'b1;
    wait_n = 0;
    while (rstate !== 1'b0 && wait_n < 12) begin
      @(negedge clk);
      wait_n++;
    end
    tests++; if (rstate !== 1'b0) begin fails++; $display("FAIL glitch_return got %b want 0 within 12 cycles", rstate); end
    idle(2 * CPB);
    tests++; if (got_q.size() !== 0) begin fails++; $display("FAIL glitch_done got %0d bytes want 0", got_q.size()); end
    tests++; if (err_cnt !== err0) begin fails++; $display("FAIL glitch_ferr got %0d want %0d", err_cnt, err0); end
    got_q.delete();
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0, CPB);
    repeat (40) @(negedge clk);
    tests++; if (err_cnt !== exp_err) begin fails++; $display("FAIL ferr_count got %0d want %0d", err_cnt, exp_err); end
    tests++; if (got_q.size() !== 0) begin fails++; $display("FAIL ferr_done got %0d bytes want 0", got_q.size()); end
    tests++; if (rx_byte !== last_good) begin fails++; $display("FAIL ferr_hold got %h want %h", rx_byte, last_good); end
    tests++; if (rstate !== 1'b0) begin fails++; $display("FAIL ferr_break_state got %b want 0", rstate); end
    idle(2 * CPB);
    tests++; if (rstate !== 1'b0) begin fails++; $display("FAIL ferr_no_restart got %b want 0", rstate); end
    send_frame(8'h11, 1'b1, CPB);
    idle(2 * CPB);
    tests++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL ferr_next_count got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      tests++; if (got_q[0] !== exp_q[0]) begin fails++; $display("FAIL ferr_next_byte got %h want %h", got_q[0], exp_q[0]); end
      void'(got_q.pop_front()); void'(exp_q.pop_front());
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_mid_reset();
    logic [7:0] b;
    b = 8'h96;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = b[4];
    repeat (CPB / 2) @(negedge clk);
    tests++; if (rstate !== 1'b1) begin fails++; $display("FAIL rst_busy got %b want 1", rstate); end
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    tests++; if ({rx_byte, done, ferr, rstate} !== 11'd0) begin fails++; $display("FAIL rst_mid got %h want 000", {rx_byte, done, ferr, rstate}); end
    rst = 1'b0;
    last_good = 8'h00;
    idle(2 * CPB);
    tests++; if (got_q.size() !== 0) begin fails++; $display("FAIL rst_partial got %0d bytes want 0", got_q.size()); end
    got_q.delete();
    send_frame(8'h5A, 1'b1, CPB);
    idle(2 * CPB);
    tests++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL rst_next_count got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      tests++; if (got_q[0] !== exp_q[0]) begin fails++; $display("FAIL rst_next_byte got %h want %h", got_q[0], exp_q[0]); end
      void'(got_q.pop_front()); void'(exp_q.pop_front());
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_baud_tolerance();
    send_frame(8'hC3, 1'b1, CPB - 1);
    idle(2 * CPB);
    send_frame(8'hC3, 1'b1, CPB + 1);
    idle(2 * CPB);
    tests++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL baud_count got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      tests++; if (got_q[0] !== exp_q[0]) begin fails++; $display("FAIL baud_byte got %h want %h", got_q[0], exp_q[0]); end
      void'(got_q.pop_front()); void'(exp_q.pop_front());
    end
    got_q.delete(); exp_q.delete();
    tests++; if (err_cnt !== exp_err) begin fails++; $display("FAIL baud_ferr got %0d want %0d", err_cnt, exp_err); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       bad;
    int         gap;
    for (int n = 0; n < 24; n++) begin
      b   = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0);
      send_frame(b, !bad, CPB);
      gap = bad ? CPB + int'($urandom_range(0, 8)) : int'($urandom_range(0, 12));
      if (gap > 0) idle(gap);
    end
    idle(2 * CPB);
    tests++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      tests++; if (got_q[0] !== exp_q[0]) begin fails++; $display("FAIL rand_byte got %h want %h", got_q[0], exp_q[0]); end
      void'(got_q.pop_front()); void'(exp_q.pop_front());
    end
    got_q.delete(); exp_q.delete();
    tests++; if (err_cnt !== exp_err) begin fails++; $display("FAIL rand_ferr got %0d want %0d", err_cnt, exp_err); end
    tests++; if (rx_byte !== last_good) begin fails++; $display("FAIL rand_hold got %h want %h", rx_byte, last_good); end
    tests++; if (both_cnt !== 0) begin fails++; $display("FAIL done_and_ferr got %0d overlaps want 0", both_cnt); end
    tests++; if (dbl_cnt !== 0) begin fails++; $display("FAIL pulse_width got %0d long pulses want 0", dbl_cnt); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_mid_reset();
    test_baud_tolerance();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
